// File: rtl/instr_fetch_unit_pkg.sv
// rtl/instr_fetch_unit_pkg.sv - shared types and constants for the instruction fetch unit
package instr_fetch_unit_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2,
    HOLD  = 2'd3
  } fetch_state_t;

  localparam logic [31:0] NOP_WORD      = 32'h0;
  localparam logic [3:0]  TIMEOUT_LIMIT = 4'd15;

endpackage

// File: rtl/instr_fetch_unit_skid_buf.sv
// rtl/instr_fetch_unit_skid_buf.sv - one-entry skid register for a fetched word the decoder could not take
module fetch_skid_buf
  import instr_fetch_unit_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic        unload,
  input  logic        clear,
  input  logic [31:0] load_inst,
  input  logic [31:0] load_pc,
  output logic [31:0] skid_inst,
  output logic [31:0] skid_pc,
  output logic        skid_valid
);

  logic [31:0] inst_q, inst_d;
  logic [31:0] pc_q, pc_d;
  logic        valid_q, valid_d;

  always_comb begin
    inst_d  = inst_q;
    pc_d    = pc_q;
    valid_d = valid_q;
    if (clear) begin
      valid_d = 1'b0;
    end else if (load) begin
      inst_d  = load_inst;
      pc_d    = load_pc;
      valid_d = 1'b1;
    end else if (unload) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      inst_q  <= NOP_WORD;
      pc_q    <= 32'h0;
      valid_q <= 1'b0;
    end else begin
      inst_q  <= inst_d;
      pc_q    <= pc_d;
      valid_q <= valid_d;
    end
  end

  assign skid_inst  = inst_q;
  assign skid_pc    = pc_q;
  assign skid_valid = valid_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - fetch FSM between the PC, instruction memory and decode
// Optional request timeout is enabled by defining FETCH_TIMEOUT_EN.
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc_addr,
  input  logic        flush,
  input  logic        dec_stall,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] inst_out,
  output logic [31:0] inst_pc,
  output logic        inst_valid,
  output logic        fetch_stall,
  output logic        fetch_err
);

  fetch_state_t state_q, state_d;
  logic [31:0]  inst_out_q, inst_out_d;
  logic [31:0]  inst_pc_q, inst_pc_d;
  logic         inst_valid_q, inst_valid_d;
  logic [31:0]  req_addr_q, req_addr_d;

  logic         slot_free;
  logic         req_c, stall_c;
  logic         skid_load, skid_unload, skid_clear;
  logic [31:0]  skid_inst, skid_pc;
  logic         skid_valid;
  logic         timeout;

  fetch_skid_buf u_skid (
    .clk        (clk),
    .reset      (reset),
    .load       (skid_load),
    .unload     (skid_unload),
    .clear      (skid_clear),
    .load_inst  (imem_rdata),
    .load_pc    (pc_addr),
    .skid_inst  (skid_inst),
    .skid_pc    (skid_pc),
    .skid_valid (skid_valid)
  );

  assign slot_free = !inst_valid_q || !dec_stall;

  always_comb begin
    state_d      = state_q;
    inst_out_d   = inst_out_q;
    inst_pc_d    = inst_pc_q;
    inst_valid_d = slot_free ? 1'b0 : inst_valid_q;
    req_addr_d   = req_addr_q;
    req_c        = 1'b0;
    stall_c      = 1'b1;
    imem_addr    = pc_addr;
    skid_load    = 1'b0;
    skid_unload  = 1'b0;
    skid_clear   = 1'b0;

    if (flush) begin
      stall_c      = 1'b0;
      inst_valid_d = 1'b0;
      skid_clear   = 1'b1;
    end

    case (state_q)
      IDLE: state_d = FETCH;
      FETCH: begin
        req_c = 1'b1;
        if (flush) begin
          // Without an ack the memory still owes a response for this address.
          if (!imem_ack) begin
            req_addr_d = pc_addr;
            state_d    = DRAIN;
          end
        end else if (imem_ack) begin
          stall_c = 1'b0;
          if (slot_free) begin
            inst_out_d   = imem_rdata;
            inst_pc_d    = pc_addr;
            inst_valid_d = 1'b1;
          end else begin
            skid_load = 1'b1;
            state_d   = HOLD;
          end
        end
      end
      DRAIN: begin
        req_c     = 1'b1;
        imem_addr = req_addr_q;
        if (imem_ack) state_d = FETCH;
      end
      HOLD: begin
        if (flush) begin
          state_d = FETCH;
        end else if (!dec_stall && skid_valid) begin
          inst_out_d   = skid_inst;
          inst_pc_d    = skid_pc;
          inst_valid_d = 1'b1;
          skid_unload  = 1'b1;
          state_d      = FETCH;
        end
      end
      default: state_d = IDLE;
    endcase

    if (timeout) state_d = IDLE;
  end

`ifdef FETCH_TIMEOUT_EN
  logic [3:0] cnt_q, cnt_d;
  logic       err_q, err_d;
  logic       waiting;

  // A waiting cycle never changes state, so the count only runs within one state.
  assign waiting = (state_q == FETCH || state_q == DRAIN) && !imem_ack && !flush;
  assign timeout = waiting && (cnt_q == TIMEOUT_LIMIT - 4'd1);

  always_comb begin
    cnt_d = (waiting && !timeout) ? cnt_q + 4'd1 : 4'd0;
    err_d = timeout;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= 4'd0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign fetch_err = err_q && !reset;
`else
  assign timeout   = 1'b0;
  assign fetch_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      inst_out_q   <= NOP_WORD;
      inst_pc_q    <= 32'h0;
      inst_valid_q <= 1'b0;
      req_addr_q   <= 32'h0;
    end else begin
      state_q      <= state_d;
      inst_out_q   <= inst_out_d;
      inst_pc_q    <= inst_pc_d;
      inst_valid_q <= inst_valid_d;
      req_addr_q   <= req_addr_d;
    end
  end

  // Reset abandons any outstanding request immediately.
  assign imem_req    = req_c && !reset;
  assign fetch_stall = stall_c || reset;
  assign inst_out    = inst_out_q;
  assign inst_pc     = inst_pc_q;
  assign inst_valid  = inst_valid_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - vector table plus directed sequences for instr_fetch_unit
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc_addr;
  logic        flush;
  logic        dec_stall;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] inst_out;
  logic [31:0] inst_pc;
  logic        inst_valid;
  logic        fetch_stall;
  logic        fetch_err;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  instr_fetch_unit dut (
    .clk         (clk),
    .reset       (reset),
    .pc_addr     (pc_addr),
    .flush       (flush),
    .dec_stall   (dec_stall),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .inst_out    (inst_out),
    .inst_pc     (inst_pc),
    .inst_valid  (inst_valid),
    .fetch_stall (fetch_stall),
    .fetch_err   (fetch_err)
  );

  typedef struct {
    logic        rst;
    logic [31:0] pc;
    logic        fl;
    logic        ds;
    logic        ack;
    logic [31:0] rdata;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_stall;
    logic        e_valid;
    logic [31:0] e_out;
    logic [31:0] e_ipc;
  } vec_t;

  vec_t vecs[23];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic [31:0] pc, input logic fl, input logic ds,
                       input logic ack, input logic [31:0] rd);
    reset = r; pc_addr = pc; flush = fl; dec_stall = ds; imem_ack = ack; imem_rdata = rd;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    drive(1'b1, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    @(posedge clk); #1;
  endtask

  initial begin
    //          rst  pc           fl   ds   ack  rdata          req  addr         stall valid out            ipc
    vecs[0]  = '{1'b1, 32'h0,   1'b0, 1'b0, 1'b0, 32'h0,    1'b0, 32'h0,   1'b1, 1'b0, 32'h0,  32'h0};
    vecs[1]  = '{1'b0, 32'h0,   1'b0, 1'b0, 1'b1, 32'hA0,   1'b0, 32'h0,   1'b1, 1'b0, 32'h0,  32'h0};
    vecs[2]  = '{1'b0, 32'h0,   1'b0, 1'b0, 1'b1, 32'h11,   1'b1, 32'h0,   1'b0, 1'b0, 32'h0,  32'h0};
    vecs[3]  = '{1'b0, 32'h4,   1'b0, 1'b0, 1'b1, 32'h22,   1'b1, 32'h4,   1'b0, 1'b1, 32'h11, 32'h0};
    vecs[4]  = '{1'b0, 32'h8,   1'b0, 1'b1, 1'b1, 32'h33,   1'b1, 32'h8,   1'b0, 1'b1, 32'h22, 32'h4};
    vecs[5]  = '{1'b0, 32'hC,   1'b0, 1'b1, 1'b0, 32'h0,    1'b0, 32'hC,   1'b1, 1'b1, 32'h22, 32'h4};
    vecs[6]  = '{1'b0, 32'hC,   1'b0, 1'b0, 1'b0, 32'h0,    1'b0, 32'hC,   1'b1, 1'b1, 32'h22, 32'h4};
    vecs[7]  = '{1'b0, 32'hC,   1'b0, 1'b0, 1'b0, 32'h0,    1'b1, 32'hC,   1'b1, 1'b1, 32'h33, 32'h8};
    vecs[8]  = '{1'b0, 32'hC,   1'b0, 1'b0, 1'b0, 32'h0,    1'b1, 32'hC,   1'b1, 1'b0, 32'h33, 32'h8};
    vecs[9]  = '{1'b0, 32'hC,   1'b0, 1'b0, 1'b1, 32'h44,   1'b1, 32'hC,   1'b0, 1'b0, 32'h33, 32'h8};
    vecs[10] = '{1'b0, 32'h40,  1'b0, 1'b0, 1'b0, 32'h0,    1'b1, 32'h40,  1'b1, 1'b1, 32'h44, 32'hC};
    vecs[11] = '{1'b0, 32'h40,  1'b0, 1'b0, 1'b0, 32'h0,    1'b1, 32'h40,  1'b1, 1'b0, 32'h44, 32'hC};
    vecs[12] = '{1'b0, 32'h40,  1'b0, 1'b0, 1'b0, 32'h0,    1'b1, 32'h40,  1'b1, 1'b0, 32'h44, 32'hC};
    vecs[13] = '{1'b0, 32'h40,  1'b0, 1'b0, 1'b1, 32'h55,   1'b1, 32'h40,  1'b0, 1'b0, 32'h44, 32'hC};
    vecs[14] = '{1'b0, 32'h10,  1'b1, 1'b0, 1'b0, 32'h0,    1'b1, 32'h10,  1'b0, 1'b1, 32'h55, 32'h40};
    vecs[15] = '{1'b0, 32'h100, 1'b0, 1'b0, 1'b0, 32'h0,    1'b1, 32'h10,  1'b1, 1'b0, 32'h55, 32'h40};
    vecs[16] = '{1'b0, 32'h100, 1'b0, 1'b0, 1'b1, 32'hDEAD, 1'b1, 32'h10,  1'b1, 1'b0, 32'h55, 32'h40};
    vecs[17] = '{1'b0, 32'h100, 1'b0, 1'b0, 1'b1, 32'h66,   1'b1, 32'h100, 1'b0, 1'b0, 32'h55, 32'h40};
    vecs[18] = '{1'b0, 32'h104, 1'b1, 1'b0, 1'b1, 32'h77,   1'b1, 32'h104, 1'b0, 1'b1, 32'h66, 32'h100};
    vecs[19] = '{1'b0, 32'h200, 1'b0, 1'b0, 1'b0, 32'h0,    1'b1, 32'h200, 1'b1, 1'b0, 32'h66, 32'h100};
    vecs[20] = '{1'b1, 32'h200, 1'b0, 1'b0, 1'b0, 32'h0,    1'b0, 32'h200, 1'b1, 1'b0, 32'h66, 32'h100};
    vecs[21] = '{1'b0, 32'h200, 1'b0, 1'b0, 1'b1, 32'h88,   1'b0, 32'h200, 1'b1, 1'b0, 32'h0,  32'h0};
    vecs[22] = '{1'b0, 32'h200, 1'b0, 1'b0, 1'b0, 32'h0,    1'b1, 32'h200, 1'b1, 1'b0, 32'h0,  32'h0};

    drive(1'b1, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    do_reset();

    for (int i = 0; i < 23; i++) begin
      drive(vecs[i].rst, vecs[i].pc, vecs[i].fl, vecs[i].ds, vecs[i].ack, vecs[i].rdata);
      @(negedge clk);
      check($sformatf("v%0d imem_req", i), {31'b0, imem_req}, {31'b0, vecs[i].e_req});
      check($sformatf("v%0d imem_addr", i), imem_addr, vecs[i].e_addr);
      check($sformatf("v%0d fetch_stall", i), {31'b0, fetch_stall}, {31'b0, vecs[i].e_stall});
      check($sformatf("v%0d inst_valid", i), {31'b0, inst_valid}, {31'b0, vecs[i].e_valid});
      check($sformatf("v%0d inst_out", i), inst_out, vecs[i].e_out);
      check($sformatf("v%0d inst_pc", i), inst_pc, vecs[i].e_ipc);
      check($sformatf("v%0d fetch_err", i), {31'b0, fetch_err}, 32'h0);
      @(posedge clk); #1;
    end

    // Zero-wait memory: one instruction per cycle, PC advancing by 4 on each unstalled edge.
    begin
      logic [31:0] pc;
      pc = 32'h0;
      do_reset();
      for (int k = 0; k < 8; k++) begin
        drive(1'b0, pc, 1'b0, 1'b0, 1'b1, 32'h1000 + pc);
        @(negedge clk);
        check($sformatf("zw%0d stall", k), {31'b0, fetch_stall}, (k == 0) ? 32'h1 : 32'h0);
        if (k >= 2) begin
          check($sformatf("zw%0d inst_pc", k), inst_pc, 32'(4 * (k - 2)));
          check($sformatf("zw%0d inst_out", k), inst_out, 32'h1000 + 32'(4 * (k - 2)));
          check($sformatf("zw%0d valid", k), {31'b0, inst_valid}, 32'h1);
        end
        @(posedge clk); #1;
        if (k >= 1) pc = pc + 32'd4;
      end
    end

    // Request never acknowledged.
    begin
      int err_pulses;
      err_pulses = 0;
      do_reset();
      for (int k = 0; k < 20; k++) begin
        drive(1'b0, 32'h300, 1'b0, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        if (fetch_err) err_pulses++;
`ifdef FETCH_TIMEOUT_EN
        if (k == 16) begin
          check("to err at c16", {31'b0, fetch_err}, 32'h1);
          check("to idle req", {31'b0, imem_req}, 32'h0);
        end
        if (k == 17) begin
          check("to refetch req", {31'b0, imem_req}, 32'h1);
          check("to refetch addr", imem_addr, 32'h300);
        end
`else
        if (k >= 1) check($sformatf("nto%0d req held", k), {31'b0, imem_req}, 32'h1);
`endif
        @(posedge clk); #1;
      end
`ifdef FETCH_TIMEOUT_EN
      check("to err pulses", 32'(err_pulses), 32'h1);
`else
      check("nto err pulses", 32'(err_pulses), 32'h0);
`endif
    end

    // Flush while in HOLD discards the skid word and returns to FETCH.
    do_reset();
    drive(1'b0, 32'h20, 1'b0, 1'b0, 1'b1, 32'hAA);   // IDLE
    @(posedge clk); #1;
    drive(1'b0, 32'h20, 1'b0, 1'b0, 1'b1, 32'hAA);   // FETCH, present 0x20
    @(posedge clk); #1;
    drive(1'b0, 32'h24, 1'b0, 1'b1, 1'b1, 32'hBB);   // FETCH, slot busy -> HOLD
    @(posedge clk); #1;
    drive(1'b0, 32'h28, 1'b1, 1'b1, 1'b0, 32'h0);    // HOLD with flush
    @(negedge clk);
    check("hold flush stall", {31'b0, fetch_stall}, 32'h0);
    check("hold flush req", {31'b0, imem_req}, 32'h0);
    @(posedge clk); #1;
    drive(1'b0, 32'h80, 1'b0, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    check("post flush valid", {31'b0, inst_valid}, 32'h0);
    check("post flush req", {31'b0, imem_req}, 32'h1);
    check("post flush addr", imem_addr, 32'h80);
    @(posedge clk); #1;
    drive(1'b0, 32'h80, 1'b0, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    check("skid cleared", {31'b0, inst_valid}, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
